// File: rtl/tsmac_tx_fifo_drain.sv
// TSMAC TX FIFO drain: streams committed frames from a 1-cycle-latency FIFO onto
// the MAC TX valid/ready/last interface through a 2-entry skid buffer, and inserts
// an inter-frame gap after each frame.
module tsmac_tx_fifo_drain #(
  parameter int DATA_WIDTH    = 8,
  parameter int IFG_CYCLES    = 12,
  parameter int FRM_CNT_WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_commit,
  input  logic [DATA_WIDTH:0]      fifo_rd_data,
  input  logic                     fifo_rd_empty,
  output logic                     fifo_rd_en,
  output logic [DATA_WIDTH-1:0]    tx_data,
  output logic                     tx_valid,
  output logic                     tx_last,
  input  logic                     tx_ready,
  output logic                     tx_underrun,
  output logic [FRM_CNT_WIDTH-1:0] frame_pending,
  output logic                     frm_cnt_ovf,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, SEND, IFG} state_t;

  localparam int IFG_W      = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam int IFG_LOAD_I = (IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0;
  localparam logic [IFG_W-1:0]         IFG_LOAD = IFG_W'(IFG_LOAD_I);
  localparam logic [FRM_CNT_WIDTH-1:0] FRM_MAX  = '1;

  state_t                  state;
  logic [DATA_WIDTH:0]     slot0;
  logic [DATA_WIDTH:0]     slot1;
  logic [1:0]              occ;
  logic                    inflight;
  logic                    last_fetched;
  logic                    arm;
  logic [IFG_W-1:0]        ifg_cnt;

  logic                    beat_acc;
  logic                    last_acc;
  logic                    last_landing;
  logic                    rd_acc;
  logic                    starve;
  logic                    dec;
  logic [2:0]              fill_after_pop;

  assign tx_valid = (occ != 2'd0);
  assign tx_data  = slot0[DATA_WIDTH-1:0];
  assign tx_last  = tx_valid & slot0[DATA_WIDTH];
  assign busy     = (state != IDLE);

  assign beat_acc     = tx_valid & tx_ready;
  assign last_acc     = beat_acc & slot0[DATA_WIDTH];
  // The last flag of an in-flight word is visible on fifo_rd_data the cycle it lands,
  // one cycle before last_fetched can register it; gating on it keeps the next frame unread.
  assign last_landing = inflight & fifo_rd_data[DATA_WIDTH];
  // Occupancy counts the beat leaving this cycle so a full-rate stream needs no bubble;
  // the buffer still never holds more than two words.
  assign fill_after_pop = {1'b0, occ} - {2'b00, beat_acc} + {2'b00, inflight};

  assign fifo_rd_en = (state == SEND) & ~last_fetched & ~last_landing & ~fifo_rd_empty
                    & (fill_after_pop <= 3'd1);
  assign rd_acc     = fifo_rd_en & ~fifo_rd_empty;

  assign starve = (state == SEND) & arm & (occ == 2'd0) & ~inflight & fifo_rd_empty;
  assign dec    = last_acc & (frame_pending != '0);

  // Skid buffer: captures the word read last cycle, shifts out on each accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0    <= '0;
      slot1    <= '0;
      occ      <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_acc;
      case ({inflight, beat_acc})
        2'b10: begin
          if (occ == 2'd0) slot0 <= fifo_rd_data;
          else             slot1 <= fifo_rd_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            slot0 <= fifo_rd_data;
          end else begin
            slot0 <= slot1;
            slot1 <= fifo_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Frame sequencer: IDLE -> SEND per committed frame, then the inter-frame gap; also
  // tracks end-of-frame fetch and underrun arming.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_fetched <= 1'b0;
      arm          <= 1'b0;
      ifg_cnt      <= '0;
      tx_underrun  <= 1'b0;
    end else begin
      tx_underrun <= starve;
      case (state)
        IDLE: begin
          if (frame_pending != '0) state <= SEND;
        end
        SEND: begin
          if (last_landing) last_fetched <= 1'b1;
          if (starve)        arm <= 1'b0;
          else if (beat_acc) arm <= 1'b1;
          if (last_acc) begin
            last_fetched <= 1'b0;
            arm          <= 1'b0;
            if (IFG_CYCLES == 0) begin
              state <= IDLE;
            end else begin
              state   <= IFG;
              ifg_cnt <= IFG_LOAD;
            end
          end
        end
        IFG: begin
          if (ifg_cnt == '0) state   <= IDLE;
          else               ifg_cnt <= ifg_cnt - IFG_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Committed-frame counter: saturating, with a sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_pending <= '0;
      frm_cnt_ovf   <= 1'b0;
    end else if (frame_commit && !dec) begin
      if (frame_pending == FRM_MAX) frm_cnt_ovf   <= 1'b1;
      else                          frame_pending <= frame_pending + FRM_CNT_WIDTH'(1);
    end else if (dec && !frame_commit) begin
      frame_pending <= frame_pending - FRM_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_tsmac_tx_fifo_drain.sv
// Bench for tsmac_tx_fifo_drain: FIFO model plus scoreboard of expected beats,
// a table of single-frame vectors and hand-written multi-cycle sequences.
module tb_tsmac_tx_fifo_drain;

  localparam int DW  = 8;
  localparam int IFG = 12;
  localparam int FCW = 6;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           frame_commit = 1'b0;
  logic [DW:0]    fifo_rd_data = '0;
  logic           fifo_rd_empty;
  logic           fifo_rd_en;
  logic [DW-1:0]  tx_data;
  logic           tx_valid;
  logic           tx_last;
  logic           tx_ready = 1'b1;
  logic           tx_underrun;
  logic [FCW-1:0] frame_pending;
  logic           frm_cnt_ovf;
  logic           busy;

  always #5 clk = ~clk;

  tsmac_tx_fifo_drain #(
    .DATA_WIDTH   (DW),
    .IFG_CYCLES   (IFG),
    .FRM_CNT_WIDTH(FCW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_commit (frame_commit),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_en   (fifo_rd_en),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_last      (tx_last),
    .tx_ready     (tx_ready),
    .tx_underrun  (tx_underrun),
    .frame_pending(frame_pending),
    .frm_cnt_ovf  (frm_cnt_ovf),
    .busy         (busy)
  );

  // FIFO model: 1-cycle read latency, every word tagged with its frame number
  logic [DW:0] mem [0:1023];
  int          frame_of [0:1023];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          reads_total = 0;
  int          early_reads = 0;
  int          frames_pushed = 0;
  int          frames_done = 0;

  assign fifo_rd_empty = (wr_ptr == rd_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= wr_ptr;
      reads_total <= 0;
    end else if (fifo_rd_en && !fifo_rd_empty) begin
      fifo_rd_data <= mem[rd_ptr];
      if (frame_of[rd_ptr] > frames_done) early_reads <= early_reads + 1;
      reads_total <= reads_total + 1;
      rd_ptr      <= rd_ptr + 1;
    end
  end

  typedef struct {
    int         len;
    logic [7:0] first;
    logic [7:0] step;
    bit         rnd;
    int         exp_lat;
    int         exp_tail;
  } vec_t;

  vec_t        vecs [4];
  logic [DW:0] exp_q [$];
  logic [DW:0] exp_word;
  int          n_total = 0;
  int          n_pass = 0;
  int          beats_total = 0;
  int          depth_viol = 0;
  int          underrun_cnt = 0;
  bit          ready_rnd = 1'b0;
  bit          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic        prev_last = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic fail_timeout(input string name);
    n_total++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  task automatic push_word(input logic [7:0] d, input logic last);
    mem[wr_ptr]      = {last, d};
    frame_of[wr_ptr] = frames_pushed;
    exp_q.push_back({last, d});
    wr_ptr++;
    if (last) frames_pushed++;
  endtask

  task automatic push_frame(input int len, input logic [7:0] first, input logic [7:0] step);
    for (int i = 0; i < len; i++) push_word(first + 8'(i) * step, i == len - 1);
  endtask

  task automatic pulse_commit();
    @(posedge clk); #1 frame_commit = 1'b1;
    @(posedge clk); #1 frame_commit = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge where the last beat is about to be taken.
  task automatic wait_last_accept(input string tag);
    int n = 0;
    while (!(tx_valid && tx_ready && tx_last) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) fail_timeout(tag);
  endtask

  // Cycles after the last beat with busy=1 and nothing on the stream.
  task automatic count_tail(output int tail);
    tail = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy && !tx_valid) tail++;
      else break;
    end
  endtask

  task automatic check_zero_outputs(input string name);
    check(name, {fifo_rd_en, tx_valid, tx_last, tx_underrun, frm_cnt_ovf, busy, frame_pending, tx_data}, '0);
  endtask

  task automatic apply_reset_now();
    rst_n = 1'b0;
    beats_total = 0;
    exp_q.delete();
    prev_stall = 1'b0;
    frames_done = frames_pushed;
  endtask

  initial begin
    int lat, tail, gap, cnt, bad;

    vecs[0] = '{len: 4,  first: 8'h11, step: 8'h11, rnd: 1'b0, exp_lat: 3, exp_tail: IFG};
    vecs[1] = '{len: 1,  first: 8'hA5, step: 8'h00, rnd: 1'b0, exp_lat: 3, exp_tail: IFG};
    vecs[2] = '{len: 64, first: 8'h00, step: 8'h03, rnd: 1'b1, exp_lat: 3, exp_tail: IFG};
    vecs[3] = '{len: 9,  first: 8'h80, step: 8'h07, rnd: 1'b1, exp_lat: 3, exp_tail: IFG};

    fork
      forever begin
        @(negedge clk);
        if (reads_total - beats_total > 2) depth_viol++;
        if (prev_stall) check("stall_hold", {tx_valid, tx_last, tx_data}, {1'b1, prev_last, prev_data});
        if (tx_underrun) underrun_cnt++;
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL sb_extra_beat: got beat %0h, expected none", {tx_last, tx_data});
          end else begin
            exp_word = exp_q.pop_front();
            check("sb_beat", {tx_last, tx_data}, exp_word);
            beats_total++;
            if (tx_last) frames_done++;
          end
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_last  = tx_last;
      end
      forever begin
        @(posedge clk); #1;
        tx_ready = ready_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
      end
    join_none

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset_outputs");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table: single frames, first beat 3 edges after the commit edge, IFG busy tail
    for (int v = 0; v < 4; v++) begin
      ready_rnd = vecs[v].rnd;
      push_frame(vecs[v].len, vecs[v].first, vecs[v].step);
      pulse_commit();
      @(negedge clk);
      check("pending_after_commit", 32'(frame_pending), 1);
      lat = 0;
      while (!tx_valid && lat < 20) begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
      check("first_valid_latency", lat, vecs[v].exp_lat);
      wait_last_accept("table_last");
      count_tail(tail);
      check("ifg_busy_cycles", tail, vecs[v].exp_tail);
      check("pending_after_frame", 32'(frame_pending), 0);
      check("sb_drained", exp_q.size(), 0);
    end
    ready_rnd = 1'b0;

    // Back-to-back frames: gap = IFG cycles + 1 IDLE cycle + 2 cycles of fetch latency
    push_frame(5, 8'h60, 8'h01);
    push_frame(3, 8'h90, 8'h01);
    @(posedge clk); #1 frame_commit = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 frame_commit = 1'b0;
    @(negedge clk);
    check("pending_two_frames", 32'(frame_pending), 2);
    wait_last_accept("b2b_first");
    gap = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!tx_valid) gap++;
      else break;
    end
    check("interframe_gap", gap, IFG + 3);
    check("pending_second_frame", 32'(frame_pending), 1);
    wait_last_accept("b2b_second");
    count_tail(tail);
    check("pending_after_b2b", 32'(frame_pending), 0);

    // Commit coincident with last-beat acceptance keeps pending at 1
    push_frame(3, 8'hC0, 8'h01);
    push_frame(2, 8'hD0, 8'h01);
    pulse_commit();
    @(negedge clk);
    wait_last_accept("coinc_first");
    frame_commit = 1'b1;
    @(posedge clk); #1 frame_commit = 1'b0;
    @(negedge clk);
    check("pending_coincident", 32'(frame_pending), 1);
    wait_last_accept("coinc_second");
    count_tail(tail);
    check("pending_after_coinc", 32'(frame_pending), 0);
    check("no_underrun_normal", underrun_cnt, 0);

    // Underrun: two words available, then the FIFO runs dry mid-frame
    push_word(8'hE1, 1'b0);
    push_word(8'hE2, 1'b0);
    pulse_commit();
    repeat (25) @(negedge clk);
    check("underrun_single_pulse", underrun_cnt, 1);
    check("underrun_busy_stalled", {busy, tx_valid}, 2'b10);
    @(posedge clk); #1;
    push_word(8'hE3, 1'b0);
    push_word(8'hE4, 1'b1);
    @(negedge clk);
    wait_last_accept("underrun_finish");
    count_tail(tail);
    check("underrun_frame_pending", 32'(frame_pending), 0);
    check("underrun_no_repeat", underrun_cnt, 1);

    // Counter saturation: 64 commits with no data
    @(posedge clk); #1 frame_commit = 1'b1;
    repeat (64) @(posedge clk);
    #1 frame_commit = 1'b0;
    @(negedge clk);
    check("pending_saturated", 32'(frame_pending), 63);
    check("ovf_sticky_set", frm_cnt_ovf, 1);

    // Asynchronous reset clears everything including the sticky flag
    @(posedge clk); #3;
    apply_reset_now();
    #1 check_zero_outputs("async_reset_saturated");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Reset in the middle of a frame
    push_frame(8, 8'h50, 8'h01);
    pulse_commit();
    cnt = 0;
    for (int k = 0; k < 40 && cnt < 2; k++) begin
      @(negedge clk);
      if (tx_valid && tx_ready) cnt++;
    end
    if (cnt < 2) fail_timeout("midframe_beats");
    @(posedge clk); #3;
    apply_reset_now();
    #1 check_zero_outputs("async_reset_midframe");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy || tx_valid || fifo_rd_en || frame_pending != '0) bad++;
    end
    check("idle_after_reset", bad, 0);

    check("buffer_depth_le2", depth_viol, 0);
    check("no_early_next_frame_read", early_reads, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
